// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types for the sequential binary-to-BCD converter: FSM states, digit type, blank code.
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
   typedef logic [3:0] bcd_digit_t;
   localparam bcd_digit_t BCD_BLANK = 4'hF;
endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more; purely combinational.
module bcd_add3
   import bcd_pkg::*;
(
   input  bcd_digit_t in_i,
   output bcd_digit_t out_o
);
   assign out_o = (in_i >= 4'd5) ? bcd_digit_t'(in_i + 4'd3) : in_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary to BCD, one bit per clock; done pulses WIDTH+1 cycles after start, start ignored while busy.
// Build with LEADING_ZERO_BLANK_EN to replace leading zero digits (never digit 0) with BCD_BLANK.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [BW-1:0] BCD_RST = {BW{1'b1}} << 4;
`else
   localparam logic [BW-1:0] BCD_RST = '0;
`endif

   bcd_state_t      state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [BW-1:0]   dig_q, dig_d, dig_adj;
   logic [BW-1:0]   bcd_q, bcd_d, bcd_fmt;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_acc_q, ovf_acc_d;
   logic            ovf_q, ovf_d;
   logic            done_q, done_d;

   for (genvar k = 0; k < DIGITS; k++) begin : g_add3
      bcd_add3 u_add3 (
         .in_i  (dig_q[4*k +: 4]),
         .out_o (dig_adj[4*k +: 4])
      );
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lead;
   always_comb begin
      bcd_fmt = dig_q;
      lead    = 1'b1;
      // Walk down from the top digit; digit 0 always shows a value.
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (lead && (dig_q[4*k +: 4] == 4'd0)) begin
            bcd_fmt[4*k +: 4] = BCD_BLANK;
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   assign bcd_fmt = dig_q;
`endif

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      dig_d     = dig_q;
      cnt_d     = cnt_q;
      ovf_acc_d = ovf_acc_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               sr_d      = bin;
               dig_d     = '0;
               cnt_d     = '0;
               ovf_acc_d = 1'b0;
            end
         end
         SHIFT: begin
            // The bit shifted out of the top digit means the value no longer fits.
            {dig_d, sr_d} = {dig_adj[BW-2:0], sr_q, 1'b0};
            ovf_acc_d     = ovf_acc_q | dig_adj[BW-1];
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d   = bcd_fmt;
            ovf_d   = ovf_acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         dig_q     <= '0;
         cnt_q     <= '0;
         ovf_acc_q <= 1'b0;
         bcd_q     <= BCD_RST;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         dig_q     <= dig_d;
         cnt_q     <= cnt_d;
         ovf_acc_q <= ovf_acc_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance, both WIDTH=8.
module tb_bin_to_bcd_seq;
   logic        clk = 1'b0;
   logic        reset_n, start, start2;
   logic [7:0]  bin, bin2;
   logic        busy, done, ovf, busy2, done2, ovf2;
   logic [11:0] bcd;
   logic [7:0]  bcd2;
   int          errors = 0;
   int          checks = 0;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif
   localparam logic [11:0] RST3 = BLANK ? 12'hFF0 : 12'h000;
   localparam logic [7:0]  RST2 = BLANK ? 8'hF0 : 8'h00;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
   );

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .bin(bin2),
      .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
   );

   // Issue one start, then scramble bin; lat counts edges after the accepting edge.
   task automatic run_conv(input logic [7:0] v, output logic [11:0] b, output logic o,
                           output int lat, output logic busy_first);
      @(negedge clk); bin = v; start = 1'b1;
      @(negedge clk); start = 1'b0; bin = ~v;
      busy_first = busy;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk); lat++;
      end
      b = bcd; o = ovf;
   endtask

   task automatic run_conv2(input logic [7:0] v, output logic [7:0] b, output logic o,
                            output int lat);
      @(negedge clk); bin2 = v; start2 = 1'b1;
      @(negedge clk); start2 = 1'b0; bin2 = ~v;
      lat = 0;
      while (done2 !== 1'b1 && lat < 40) begin
         @(negedge clk); lat++;
      end
      b = bcd2; o = ovf2;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; start2 = 1'b0; bin = 8'hA5; bin2 = 8'h5A;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (bcd !== RST3) begin errors++; $display("FAIL reset_bcd: got %h expected %h", bcd, RST3); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      checks++; if (bcd2 !== RST2) begin errors++; $display("FAIL reset_bcd2: got %h expected %h", bcd2, RST2); end
      checks++; if (busy2 !== 1'b0 || ovf2 !== 1'b0) begin
         errors++; $display("FAIL reset_dut2: got busy=%b ovf=%b expected 0 0", busy2, ovf2);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero;
      logic [11:0] b; logic o, bf; int lat;
      run_conv(8'd0, b, o, lat, bf);
      checks++; if (bf !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b expected 1", bf); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL zero_latency: got %0d expected 9", lat); end
      checks++; if (b !== (BLANK ? 12'hFF0 : 12'h000)) begin
         errors++; $display("FAIL zero_bcd: got %h expected %h", b, BLANK ? 12'hFF0 : 12'h000);
      end
      checks++; if (o !== 1'b0) begin errors++; $display("FAIL zero_ovf: got %b expected 0", o); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done); end
   endtask

   task automatic test_values;
      logic [11:0] b; logic o, bf; int lat;
      run_conv(8'd255, b, o, lat, bf);
      checks++; if (b !== 12'h255) begin errors++; $display("FAIL bcd_255: got %h expected 255", b); end
      checks++; if (o !== 1'b0) begin errors++; $display("FAIL ovf_255: got %b expected 0", o); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL latency_255: got %0d expected 9", lat); end
      // Result must hold while the next conversion is in flight.
      @(negedge clk); bin = 8'd100; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (bcd !== 12'h255 || done !== 1'b0) begin
         errors++; $display("FAIL hold_midconv: got bcd=%h done=%b expected 255 0", bcd, done);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      checks++; if (bcd !== 12'h100) begin errors++; $display("FAIL bcd_100: got %h expected 100", bcd); end
      run_conv(8'd9, b, o, lat, bf);
      checks++; if (b !== (BLANK ? 12'hFF9 : 12'h009)) begin
         errors++; $display("FAIL bcd_9: got %h expected %h", b, BLANK ? 12'hFF9 : 12'h009);
      end
      run_conv(8'd40, b, o, lat, bf);
      checks++; if (b !== (BLANK ? 12'hF40 : 12'h040)) begin
         errors++; $display("FAIL bcd_40: got %h expected %h", b, BLANK ? 12'hF40 : 12'h040);
      end
   endtask

   task automatic test_back_to_back;
      int          edges[$];
      logic [11:0] vals[$];
      int          lat;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin edges.push_back(i - 1); vals.push_back(bcd); end
         bin = 8'((i * 37 + 5) % 256); start = 1'b1;
      end
      @(negedge clk); start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      checks++; if (edges.size() !== 3) begin
         errors++; $display("FAIL b2b_done_count: got %0d expected 3", edges.size());
      end
      if (edges.size() >= 3) begin
         checks++; if (edges[0] !== 9 || edges[1] !== 19 || edges[2] !== 29) begin
            errors++; $display("FAIL b2b_done_edges: got %0d %0d %0d expected 9 19 29", edges[0], edges[1], edges[2]);
         end
         checks++; if (vals[0] !== (BLANK ? 12'hFF5 : 12'h005)) begin
            errors++; $display("FAIL b2b_val0: got %h expected %h", vals[0], BLANK ? 12'hFF5 : 12'h005);
         end
         checks++; if (vals[1] !== 12'h119) begin errors++; $display("FAIL b2b_val1: got %h expected 119", vals[1]); end
         checks++; if (vals[2] !== 12'h233) begin errors++; $display("FAIL b2b_val2: got %h expected 233", vals[2]); end
      end
      checks++; if (lat >= 40) begin errors++; $display("FAIL b2b_drain: got timeout expected done"); end
   endtask

   task automatic test_reset_mid;
      logic [11:0] b; logic o, bf; int lat; int seen;
      @(negedge clk); bin = 8'd77; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL midreset_ctrl: got busy=%b done=%b expected 0 0", busy, done);
      end
      checks++; if (bcd !== RST3) begin errors++; $display("FAIL midreset_bcd: got %h expected %h", bcd, RST3); end
      reset_n = 1'b1;
      seen = 0;
      repeat (12) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_discard: got %0d active cycles expected 0", seen); end
      run_conv(8'd173, b, o, lat, bf);
      checks++; if (b !== 12'h173 || lat !== 9) begin
         errors++; $display("FAIL after_reset_conv: got %h lat=%0d expected 173 lat=9", b, lat);
      end
   endtask

   task automatic test_two_digit;
      logic [7:0] b; logic o; int lat;
      run_conv2(8'd137, b, o, lat);
      checks++; if (b !== 8'h37) begin errors++; $display("FAIL d2_bcd_137: got %h expected 37", b); end
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL d2_ovf_137: got %b expected 1", o); end
      run_conv2(8'd99, b, o, lat);
      checks++; if (b !== 8'h99) begin errors++; $display("FAIL d2_bcd_99: got %h expected 99", b); end
      checks++; if (o !== 1'b0) begin errors++; $display("FAIL d2_ovf_99: got %b expected 0", o); end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_values();
      test_back_to_back();
      test_reset_mid();
      test_two_digit();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
